// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM state encoding and constants for the iterative mul/div sequencer.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

  // Signed variants are the odd opcodes.
  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of MSB-first shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic                 is_div,
  input  logic [CNT_W-1:0]     cnt,
  input  logic [WIDTH-1:0]     ma,
  input  logic [WIDTH-1:0]     mb,
  input  logic [2*WIDTH-1:0]   acc,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic             op_bit;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // ~cnt walks the operand from its MSB since 2**CNT_W == WIDTH.
    op_bit   = is_div ? ma[~cnt] : mb[~cnt];
    trial    = {acc[2*WIDTH-1:WIDTH], op_bit};
    diff     = trial[WIDTH-1:0] - mb;
    acc_next = '0;
    if (is_div) begin
      // Divide: upper half is the partial remainder, lower half collects quotient bits.
      if (trial >= {1'b0, mb}) begin
        acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {acc[2*WIDTH-2:0], 1'b0} + (op_bit ? {{WIDTH{1'b0}}, ma} : '0);
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MFHI/MTHI/MTLO service
// and a pipeline stall while a result is pending.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mf_req,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_step, prod;
  logic [WIDTH-1:0]   ma_q, mb_q, hi_q, lo_q, res_hi, res_lo;
  logic               sa_q, sb_q, div_q, last, sa_in, sb_in;

  muldiv_step #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_step (
    .is_div  (div_q),
    .cnt     (cnt_q),
    .ma      (ma_q),
    .mb      (mb_q),
    .acc     (acc_q),
    .acc_next(acc_step)
  );

  assign last  = (cnt_q == CNT_W'(WIDTH - 1));
  assign sa_in = op_is_signed(op) & a[WIDTH-1];
  assign sb_in = op_is_signed(op) & b[WIDTH-1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      ST_RUN:           if (last) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Sign fixup applied to the final iteration's accumulator.
  always_comb begin
    prod   = (sa_q ^ sb_q) ? -acc_step : acc_step;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (div_q) begin
      res_lo = (sa_q ^ sb_q) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
      res_hi = sa_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
      // A zero divisor leaves the remainder equal to |a|, so HI already restores a.
      if (mb_q == '0) res_lo = WIDTH'(DIV0_LO);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RUN) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last) begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
      end else begin
        if (wr_hi) hi_q <= wdata;
        if (wr_lo) lo_q <= wdata;
        if (start) begin
          ma_q  <= sa_in ? -a : a;
          mb_q  <= sb_in ? -b : b;
          sa_q  <= sa_in;
          sb_q  <= sb_in;
          div_q <= op[1];
          acc_q <= '0;
          cnt_q <= '0;
        end
      end
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign stall = busy & (start | mf_req | wr_hi | wr_lo);

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected {HI,LO}, a monitor checks on done.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, start, mf_req, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, hi, lo;
  logic        busy, done, stall;

  logic [63:0] sb_q[$];
  int          n_checks = 0;
  int          n_fails  = 0;

  always #5 clk = ~clk;

  muldiv_seq #(
    .WIDTH(32),
    .CNT_W(5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mf_req(mf_req),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .stall (stall)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL sb_unexpected_done: got done=1, expected no pending result");
        end else begin
          e = sb_q.pop_front();
          check("sb_hi", {32'h0, hi}, {32'h0, e[63:32]});
          check("sb_lo", {32'h0, lo}, {32'h0, e[31:0]});
        end
      end
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] eh, input logic [31:0] el);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    sb_q.push_back({eh, el});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle; checks latency and busy duration.
  task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
    int lat;
    int nbusy;
    lat   = 0;
    nbusy = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (busy === 1'b1) nbusy++;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy_cycles"}, 64'(nbusy), 64'(exp_busy));
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    a      = '0;
    b      = '0;
    mf_req = 1'b0;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
    wdata  = '0;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_hi", {32'h0, hi}, 64'h0);
    check("rst_lo", {32'h0, lo}, 64'h0);
    check("rst_flags", {61'h0, busy, done, stall}, 64'h0);
    @(posedge clk);
    #1;

    // Directed arithmetic vectors
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    wait_done("multu_max", 33, 32);
    issue(2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    wait_done("mult_neg", 33, 32);
    issue(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_done("div_neg", 33, 32);
    issue(2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
    wait_done("divu_zero", 33, 32);
    issue(2'b11, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    wait_done("div_zero", 33, 32);
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    wait_done("div_ovf", 33, 32);

    // mf_req and MTLO during RUN
    @(posedge clk);
    #1;
    issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6);
    repeat (4) @(posedge clk);
    #1;
    mf_req = 1'b1;
    wr_lo  = 1'b1;
    wdata  = 32'h1234;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_mt_run", {63'h0, stall}, 64'h1);
      @(posedge clk);
      #1;
    end
    wr_lo = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) break;
      check("stall_mf_run", {63'h0, stall}, 64'h1);
    end
    check("done_seen_mf", {63'h0, done}, 64'h1);
    check("stall_in_done", {63'h0, stall}, 64'h0);
    @(posedge clk);
    #1 mf_req = 1'b0;
    @(negedge clk);
    check("lo_hold_after_done", {32'h0, lo}, 64'd6);

    // MT writes in IDLE
    @(posedge clk);
    #1;
    wr_lo = 1'b1;
    wdata = 32'h1234;
    @(posedge clk);
    #1 wr_lo = 1'b0;
    @(negedge clk);
    check("mtlo_idle", {hi, lo}, {32'h0, 32'h1234});
    @(posedge clk);
    #1;
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    wdata = 32'hABCD;
    @(posedge clk);
    #1;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    @(negedge clk);
    check("mt_both", {hi, lo}, {32'hABCD, 32'hABCD});

    // start with MTHI: write lands, then the result overwrites it
    @(posedge clk);
    #1;
    wr_hi = 1'b1;
    wdata = 32'h55;
    issue(2'b00, 32'd6, 32'd7, 32'd0, 32'd42);
    wr_hi = 1'b0;
    @(negedge clk);
    check("mthi_with_start", {32'h0, hi}, 64'h55);
    wait_done("start_mt", 32, 31);

    // Reset in the middle of RUN
    @(posedge clk);
    #1;
    issue(2'b00, 32'd5, 32'd5, 32'd0, 32'd25);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("midrst_hilo", {hi, lo}, 64'h0);
    check("midrst_flags", {61'h0, busy, done, stall}, 64'h0);
    @(posedge clk);
    #1;
    issue(2'b00, 32'd6, 32'd7, 32'd0, 32'd42);
    wait_done("after_rst", 33, 32);

    // Back-to-back: next op presented in the DONE cycle
    @(posedge clk);
    #1;
    issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6);
    wait_done("b2b_first", 33, 32);
    issue(2'b10, 32'd9, 32'd2, 32'd1, 32'd4);
    wait_done("b2b_second", 33, 32);

    @(posedge clk);
    @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
